// File: rtl/reg32_byte_reader_if.sv
// reg32_byte_reader_if
// Bundles the word-side and byte-side handshakes of the 32-bit to 8-bit
// serializer.
//   word_in/word_valid/word_ready : 32-bit word handshake (upstream side)
//   abort                         : synchronous cancel of the word in flight
//   byte_out/byte_valid/byte_ready: 8-bit byte handshake (downstream side)
//   byte_lane                     : lane index (0..3) of byte_out
//   last                          : byte_out is the final byte of the word
//   done                          : one-cycle pulse after the final byte handshake
// master = the environment driving words and accepting bytes; slave = the serializer.
interface reg32_byte_reader_if;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        abort;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic [1:0]  byte_lane;
  logic        last;
  logic        done;

  modport master (
    output word_in, word_valid, abort, byte_ready,
    input  word_ready, byte_out, byte_valid, byte_lane, last, done
  );

  modport slave (
    input  word_in, word_valid, abort, byte_ready,
    output word_ready, byte_out, byte_valid, byte_lane, last, done
  );
endinterface

// File: rtl/reg32_byte_reader.sv
// reg32_byte_reader
// Captures a 32-bit word in one cycle and streams it out as four bytes over a
// valid/ready handshake. Lane 0 = bits [7:0], lane 3 = bits [31:24].
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : reg32_byte_reader_if.slave (word/byte handshakes, abort, done)
// Parameter:
//   MSB_FIRST : 0 sends lanes 0,1,2,3; 1 sends lanes 3,2,1,0
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a word; word_ready = 1, no byte presented
// SEND  | presenting byte number count of the held word; word_ready = 0
module reg32_byte_reader #(
  parameter bit MSB_FIRST = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  reg32_byte_reader_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] hold;
  logic [31:0] hold_nxt;
  logic [1:0]  count;
  logic [1:0]  count_nxt;
  logic        done_q;
  logic        done_nxt;
  logic [1:0]  lane;
  logic [7:0]  lane_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      hold   <= 32'd0;
      count  <= 2'd0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      hold   <= hold_nxt;
      count  <= count_nxt;
      done_q <= done_nxt;
    end
  end

  // abort outranks both word acceptance and a simultaneous byte handshake;
  // an aborted byte is treated as undelivered and never produces done.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    count_nxt = count;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.word_valid && !bus.abort) begin
          hold_nxt  = bus.word_in;
          count_nxt = 2'd0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (bus.abort) begin
          count_nxt = 2'd0;
          state_nxt = IDLE;
        end else if (bus.byte_ready) begin
          if (count == 2'd3) begin
            count_nxt = 2'd0;
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            count_nxt = count + 2'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = 2'd0;
      end
    endcase
  end

  // For MSB-first order, 3 - count equals the bitwise inverse of a 2-bit count.
  always_comb begin
    lane = 2'd0;
    if (state == SEND) begin
      lane = MSB_FIRST ? ~count : count;
    end
  end

  always_comb begin
    lane_byte = 8'd0;
    case (lane)
      2'd0:    lane_byte = hold[7:0];
      2'd1:    lane_byte = hold[15:8];
      2'd2:    lane_byte = hold[23:16];
      default: lane_byte = hold[31:24];
    endcase
  end

  // Outputs are decoded straight from registered state so an asynchronous
  // reset drives them to their idle values without waiting for a clock.
  assign bus.word_ready = (state == IDLE);
  assign bus.byte_valid = (state == SEND);
  assign bus.byte_lane  = lane;
  assign bus.byte_out   = (state == SEND) ? lane_byte : 8'd0;
  assign bus.last       = (state == SEND) && (count == 2'd3);
  assign bus.done       = done_q;

endmodule
